// File: rtl/pipe_add_if.sv
// Handshake/data bundle for pipe_add; `sub` exists only when PIPE_ADD_SUB_EN is defined.
interface pipe_add_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
`ifdef PIPE_ADD_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ovf;

`ifdef PIPE_ADD_SUB_EN
    modport master (output in_valid, a, b, ci, sub, out_ready,
                    input  in_ready, out_valid, s, co, ovf);
    modport slave  (input  in_valid, a, b, ci, sub, out_ready,
                    output in_ready, out_valid, s, co, ovf);
`else
    modport master (output in_valid, a, b, ci, out_ready,
                    input  in_ready, out_valid, s, co, ovf);
    modport slave  (input  in_valid, a, b, ci, out_ready,
                    output in_ready, out_valid, s, co, ovf);
`endif
endinterface

// File: rtl/pipe_add.sv
// Pipelined ripple-carry adder: WIDTH bits split into STAGES chunks, one chunk per stage,
// valid/ready at both ends with bubble collapse. Define PIPE_ADD_SUB_EN for a-b support.
module pipe_add #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input logic       clk,
    input logic       rst_n,
    pipe_add_if.slave bus
);
    localparam int unsigned C = WIDTH / STAGES;

    if (STAGES < 1 || STAGES > WIDTH) begin : g_bad_stages
        $error("pipe_add: STAGES must be in 1..WIDTH");
    end
    if (WIDTH % STAGES != 0) begin : g_bad_split
        $error("pipe_add: WIDTH must be a multiple of STAGES");
    end

    function automatic logic [C:0] chunk_add(input logic [C-1:0] x, input logic [C-1:0] y,
                                             input logic cin);
        logic [C-1:0] sum;
        logic         c;
        c = cin;
        for (int unsigned i = 0; i < C; i++) begin
            sum[i] = x[i] ^ y[i] ^ c;
            c      = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c, sum};
    endfunction

    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] load, adv;
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  b_d   [STAGES];
    logic              carry_q [STAGES];
    logic              carry_d [STAGES];
    logic [WIDTH-1:0]  b_eff;
    logic              c_in;
    logic [C:0]        rk;

    always_comb begin
        b_eff = bus.b;
        c_in  = bus.ci;
`ifdef PIPE_ADD_SUB_EN
        // Stage 0 stores the effective operand, so later stages never see `sub`.
        if (bus.sub) begin
            b_eff = ~bus.b;
            c_in  = 1'b1;
        end
`endif
        adv              = '0;
        adv[STAGES-1]    = bus.out_ready;
        for (int unsigned j = 1; j < STAGES; j++) begin
            adv[STAGES-1-j] = !valid_q[STAGES-j] || adv[STAGES-j];
        end

        load    = '0;
        load[0] = bus.in_valid && (!valid_q[0] || adv[0]);
        for (int unsigned k = 1; k < STAGES; k++) begin
            load[k] = valid_q[k-1] && (!valid_q[k] || adv[k]);
        end

        valid_d = valid_q;
        sum_d   = sum_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        rk      = '0;

        for (int unsigned k = 0; k < STAGES; k++) begin
            valid_d[k] = load[k] || (valid_q[k] && !adv[k]);
        end

        rk = chunk_add(bus.a[C-1:0], b_eff[C-1:0], c_in);
        if (load[0]) begin
            a_d[0]          = bus.a;
            b_d[0]          = b_eff;
            sum_d[0]        = '0;
            sum_d[0][C-1:0] = rk[C-1:0];
            carry_d[0]      = rk[C];
        end

        for (int unsigned k = 1; k < STAGES; k++) begin
            rk = chunk_add(a_q[k-1][k*C +: C], b_q[k-1][k*C +: C], carry_q[k-1]);
            if (load[k]) begin
                a_d[k]            = a_q[k-1];
                b_d[k]            = b_q[k-1];
                sum_d[k]          = sum_q[k-1];
                sum_d[k][k*C +: C] = rk[C-1:0];
                carry_d[k]        = rk[C];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                sum_q[k]   <= '0;
                a_q[k]     <= '0;
                b_q[k]     <= '0;
                carry_q[k] <= 1'b0;
            end
        end else begin
            valid_q <= valid_d;
            sum_q   <= sum_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
        end
    end

    assign bus.in_ready  = !valid_q[0] || adv[0];
    assign bus.out_valid = valid_q[STAGES-1];
    assign bus.s         = sum_q[STAGES-1];
    assign bus.co        = carry_q[STAGES-1];
    assign bus.ovf       = (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1]) &&
                           (sum_q[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);
endmodule

// File: tb/tb_pipe_add.sv
// Self-checking bench for pipe_add: directed corner ops, back-pressure, reset flush and
// randomized streams against a signed/unsigned arithmetic reference with an ordered queue.
module tb_pipe_add;
    localparam int W      = 16;
    localparam int STAGES = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_add_if #(.WIDTH(W)) bus ();
    pipe_add #(.WIDTH(W), .STAGES(STAGES)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_total = 0;
    int n_bad   = 0;

    logic [W+1:0] exp_q[$];          // {ovf, co, s}
    logic [W-1:0] cur_a, cur_b, s_hold;
    logic         cur_ci, cur_sub;
    bit           pend     = 0;
    bit           last_acc = 0;
    int           remaining = 0;
    int           accepted  = 0;
    int           delivered = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W+1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic ci, input logic sub);
        logic [W-1:0] beff;
        int           cin, us, ss;
        logic         co, ov;
        beff = sub ? ~b : b;
        cin  = sub ? 1 : int'(ci);
        us   = int'(a) + int'(beff) + cin;
        ss   = int'($signed(a)) + int'($signed(beff)) + cin;
        co   = us >= (1 << W);
        ov   = (ss >= (1 << (W-1))) || (ss < -(1 << (W-1)));
        return {ov, co, us[W-1:0]};
    endfunction

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(7))
            0:       v = '0;
            1:       v = '1;
            2:       v = {1'b0, {(W-1){1'b1}}};
            3:       v = {1'b1, {(W-1){1'b0}}};
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    function automatic logic sub_now();
`ifdef PIPE_ADD_SUB_EN
        return bus.sub;
`else
        return 1'b0;
`endif
    endfunction

    // Scoreboard: handshakes sampled mid-cycle, ahead of the edge that completes them.
    always @(negedge clk) begin
        logic [W+1:0] e;
        if (!rst_n) begin
            last_acc = 0;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                delivered++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("s",   32'(bus.s), 32'(e[W-1:0]));
                    chk("co",  32'(bus.co), 32'(e[W]));
                    chk("ovf", 32'(bus.ovf), 32'(e[W+1]));
                end
            end
            last_acc = bus.in_valid && bus.in_ready;
            if (last_acc) begin
                exp_q.push_back(ref_add(bus.a, bus.b, bus.ci, sub_now()));
                accepted++;
            end
        end
    end

    task automatic step(input int valid_pct, input int ready_pct);
        @(posedge clk);
        #1;
        if (last_acc) pend = 0;
        if (!pend && remaining > 0) begin
            cur_a   = pick();
            cur_b   = pick();
            cur_ci  = 1'($urandom_range(1));
            cur_sub = 1'($urandom_range(1));
            pend    = 1;
            remaining--;
        end
        bus.a  = cur_a;
        bus.b  = cur_b;
        bus.ci = cur_ci;
`ifdef PIPE_ADD_SUB_EN
        bus.sub = cur_sub;
`endif
        bus.in_valid  = pend && ($urandom_range(99) < valid_pct);
        bus.out_ready = $urandom_range(99) < ready_pct;
        @(negedge clk);
        #1;
    endtask

    task automatic one_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic sub, input logic [W-1:0] exp_s,
                          input logic exp_co, input logic exp_ovf);
        @(posedge clk);
        #1;
        bus.a  = a;
        bus.b  = b;
        bus.ci = ci;
`ifdef PIPE_ADD_SUB_EN
        bus.sub = sub;
`endif
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        for (int e = 1; e < STAGES; e++) begin
            chk({tag, "_early_valid"}, 32'(bus.out_valid), 0);
            @(posedge clk);
            #1;
        end
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 1);
        chk({tag, "_s"},   32'(bus.s), 32'(exp_s));
        chk({tag, "_co"},  32'(bus.co), 32'(exp_co));
        chk({tag, "_ovf"}, 32'(bus.ovf), 32'(exp_ovf));
        @(negedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.ci        = 1'b0;
        bus.out_ready = 1'b0;
`ifdef PIPE_ADD_SUB_EN
        bus.sub       = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_s", 32'(bus.s), 0);
        chk("rst_co", 32'(bus.co), 0);
        chk("rst_ovf", 32'(bus.ovf), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 1);

        one_op("basic",  16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        one_op("ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        one_op("sovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
`ifdef PIPE_ADD_SUB_EN
        one_op("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        one_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif

        // Back-pressure: fill, hold, then release for a gap-free burst.
        remaining = 8;
        accepted  = 0;
        repeat (2 * STAGES + 4) step(100, 0);
        chk("bp_accepts", 32'(accepted), 32'((STAGES < 8) ? STAGES : 8));
        chk("bp_in_ready", 32'(bus.in_ready), 32'(STAGES > 8));
        chk("bp_out_valid", 32'(bus.out_valid), 1);
        s_hold = bus.s;
        repeat (3) step(100, 0);
        chk("bp_s_stable", 32'(bus.s), 32'(s_hold));
        delivered = 0;
        repeat (8) step(100, 100);
        chk("bp_burst", 32'(delivered), 8);
        chk("bp_total_accepts", 32'(accepted), 8);

        // Reset with ops in flight.
        remaining = 3;
        repeat (3 + STAGES) step(100, 0);
        @(posedge clk);
        #2;
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 0);
        chk("midrst_s", 32'(bus.s), 0);
        exp_q.delete();
        pend      = 0;
        remaining = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(bus.in_ready), 1);
        delivered = 0;
        repeat (2 * STAGES + 4) step(100, 100);
        chk("midrst_no_stale", 32'(delivered), 0);

        // Random bubbles with out_ready=1, then random back-pressure too.
        remaining = 10000;
        for (int i = 0; i < 40000 && (remaining > 0 || pend); i++) step(60, 100);
        chk("bubble_stream_done", 32'(remaining + int'(pend)), 0);
        remaining = 2000;
        for (int i = 0; i < 20000 && (remaining > 0 || pend); i++) step(70, 60);
        chk("bp_stream_done", 32'(remaining + int'(pend)), 0);
        for (int i = 0; i < 10 * STAGES + 20 && exp_q.size() > 0; i++) step(0, 100);
        chk("drain_empty", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
